challenge_issuer: RTL and testbench
===================================

// Module: challenge_issuer
// PURPOSE
//  Transmit side of the Game of Codes code/key exchange: draws a 4-bit code from the random
//  generator, presents it to the display, and publishes the expected keypad code per the game
//  mapping table. Runs a fixed number of timed rounds, judges each keypad press, and keeps score.
//  Sits between the random sequence generator / keypad scanner and the seven-segment display.
// PARAMETERS
//  TIMEOUT_CYCLES  100_000_000  clock cycles allowed per round (1 s at 100 MHz), >=2
//  ROUNDS          8            rounds per game, 1..15
//  SCORE_W         4            score counter width; must hold ROUNDS
// PORTS
//  clk             in   1        system clock, rising edge
//  reset_n         in   1        asynchronous, active-low reset
//  start           in   1        one-cycle pulse: begin new game (ignored unless IDLE or DONE)
//  random          in   8        random generator output; bits [3:0] form the code
//  key_valid       in   1        one-cycle pulse: keypad press captured this cycle
//  key_value       in   4        pressed key code {row[1:0], col[1:0]}, sampled when key_valid=1
//  code_out        out  4        code currently presented to the player
//  code_valid      out  1        code_out is live (state WAIT_KEY)
//  expected_key    out  4        KEY_MAP[code_out]
//  result_valid    out  1        one-cycle pulse: round judged
//  result_correct  out  1        qualified by result_valid: press matched expected_key
//  result_timeout  out  1        qualified by result_valid: round ended by timeout
//  score           out  SCORE_W  correct rounds this game, saturating
//  busy            out  1        game in progress (ISSUE, WAIT_KEY, JUDGE)
//  game_over       out  1        high in DONE until next start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, score 0, round count 0, timer 0. Reset mid-round aborts at once.
//  KEY_MAP (code->key): 0->14 1->1 2->4 3->9 4->8 5->10 6->2 7->6 8->15 9->0 10->7 11->3
//   12->5 13->13 14->11 15->12.
//  FSM: IDLE -start-> ISSUE (score:=0, rounds_left:=ROUNDS). DONE -start-> same.
//   ISSUE (1 cycle): code_reg:=random[3:0]; timer:=TIMEOUT_CYCLES-1; -> WAIT_KEY.
//   WAIT_KEY: code_valid=1. key_valid -> JUDGE, correct:=(key_value==expected_key), timeout:=0.
//     else timer==0 -> JUDGE, correct:=0, timeout:=1. else timer decrements.
//     key_valid in the same cycle as timer==0: key press wins.
//   JUDGE (1 cycle): result_valid=1; score+=correct (saturate at 2^SCORE_W-1);
//     rounds_left-=1; rounds_left was 1 -> DONE, else -> ISSUE.
//  Latency: start -> code_valid 2 cycles; key_valid -> result_valid 1 cycle.
//  code_out/expected_key hold last value outside WAIT_KEY; key_valid outside WAIT_KEY ignored.
//  start while busy: ignored, no state change.
// CONFIGURATION
//  CHALLENGE_NO_REPEAT_EN defined: in ISSUE, if random[3:0]==previous round's code (same game),
//   code_reg:=random[3:0]+1 (mod 16); first round of a game never adjusted.
//  Not defined: code_reg always random[3:0]; consecutive repeats allowed.
// STRUCTURE
//  Package game_pkg: state enum {IDLE,ISSUE,WAIT_KEY,JUDGE,DONE}; localparam logic [3:0]
//   KEY_MAP[16]; function key_for_code(code). Shared with the key-evaluation logic so both ends
//   use one table.
//  Sub-module round_timer: loadable down-counter, width $clog2(TIMEOUT_CYCLES), outputs zero flag.
// TESTING
//  1 Reset, start, random=8'hA3 -> code_valid at cycle 2, code_out=3, expected_key=9;
//    key_valid key_value=9 -> next cycle result_valid, correct=1, score=1.
//  2 code 5, key_value=4 -> correct=0, timeout=0, score unchanged.
//  3 TIMEOUT_CYCLES=10, no key -> result_valid exactly 10 cycles after code_valid rises,
//    timeout=1, correct=0.
//  4 key_valid (correct key) on the cycle timer==0 -> correct=1, timeout=0.
//  5 ROUNDS=3, all correct -> three result pulses, game_over=1, score=3; start during busy ignored;
//    start in DONE -> score 0, new game.
//  6 reset_n low mid-WAIT_KEY -> all outputs 0 immediately; with CHALLENGE_NO_REPEAT_EN,
//    random[3:0]=7 twice -> second code_out=8.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the Game of Codes exchange: FSM state encoding and the
// code-to-key mapping table used by both the issuing side and key evaluation.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_KEY = 3'd2,
    JUDGE    = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam logic [3:0] KEY_MAP [16] = '{
    4'd14, 4'd1,  4'd4,  4'd9,  4'd8,  4'd10, 4'd2,  4'd6,
    4'd15, 4'd0,  4'd7,  4'd3,  4'd5,  4'd13, 4'd11, 4'd12
  };

  function automatic logic [3:0] key_for_code(input logic [3:0] code);
    return KEY_MAP[code];
  endfunction

endpackage

// File: rtl/round_timer.sv
// Loadable down-counter that times one round; zero_o flags an expired round.
module round_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  localparam int unsigned W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count: load wins over decrement
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = W'(TIMEOUT_CYCLES - 1);
    end else if (dec_i) begin
      count_d = count_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/challenge_issuer.sv
// Issues timed code/key challenges, judges keypad presses and keeps score.
// Define CHALLENGE_NO_REPEAT_EN to bump a code that repeats the previous round's.
module challenge_issuer
  import game_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned ROUNDS         = 8,
  parameter int unsigned SCORE_W        = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [7:0]         random,
  input  logic               key_valid,
  input  logic [3:0]         key_value,
  output logic [3:0]         code_out,
  output logic               code_valid,
  output logic [3:0]         expected_key,
  output logic               result_valid,
  output logic               result_correct,
  output logic               result_timeout,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               game_over
);

  state_e               state_q, state_d;
  logic [3:0]           code_q, code_d;
  logic [3:0]           exp_q, exp_d;
  logic                 correct_q, correct_d;
  logic                 timeout_q, timeout_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [3:0]           rounds_q, rounds_d;
  logic [3:0]           issue_code_s;
  logic                 timer_zero_s;
  logic                 timer_load_s;
  logic                 timer_dec_s;
  logic                 unused_s;

  assign unused_s = ^random[7:4];

  round_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (timer_load_s),
    .dec_i   (timer_dec_s),
    .zero_o  (timer_zero_s)
  );

  assign timer_load_s = (state_q == ISSUE);
  assign timer_dec_s  = (state_q == WAIT_KEY) && !key_valid && !timer_zero_s;

  // code selection; first round of a game is recognised by rounds_left==ROUNDS
  always_comb begin
    issue_code_s = random[3:0];
`ifdef CHALLENGE_NO_REPEAT_EN
    if ((rounds_q != 4'(ROUNDS)) && (random[3:0] == code_q)) begin
      issue_code_s = random[3:0] + 4'd1;
    end else begin
      issue_code_s = random[3:0];
    end
`endif
  end

  // round sequencing and judging
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    exp_d     = exp_q;
    correct_d = correct_q;
    timeout_d = timeout_q;
    score_d   = score_q;
    rounds_d  = rounds_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = ISSUE;
          score_d  = '0;
          rounds_d = 4'(ROUNDS);
        end else begin
          state_d  = state_q;
        end
      end
      ISSUE: begin
        code_d  = issue_code_s;
        exp_d   = key_for_code(issue_code_s);
        state_d = WAIT_KEY;
      end
      WAIT_KEY: begin
        if (key_valid) begin
          correct_d = (key_value == exp_q);
          timeout_d = 1'b0;
          state_d   = JUDGE;
        end else if (timer_zero_s) begin
          correct_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = JUDGE;
        end else begin
          state_d   = WAIT_KEY;
        end
      end
      JUDGE: begin
        if (correct_q && (score_q != {SCORE_W{1'b1}})) begin
          score_d = score_q + {{(SCORE_W-1){1'b0}}, 1'b1};
        end else begin
          score_d = score_q;
        end
        rounds_d = rounds_q - 4'd1;
        if (rounds_q == 4'd1) begin
          state_d = DONE;
        end else begin
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      code_q    <= 4'd0;
      exp_q     <= 4'd0;
      correct_q <= 1'b0;
      timeout_q <= 1'b0;
      score_q   <= '0;
      rounds_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      exp_q     <= exp_d;
      correct_q <= correct_d;
      timeout_q <= timeout_d;
      score_q   <= score_d;
      rounds_q  <= rounds_d;
    end
  end

  assign code_out       = code_q;
  assign expected_key   = exp_q;
  assign code_valid     = (state_q == WAIT_KEY);
  assign result_valid   = (state_q == JUDGE);
  assign result_correct = result_valid & correct_q;
  assign result_timeout = result_valid & timeout_q;
  assign score          = score_q;
  assign busy           = (state_q == ISSUE) || (state_q == WAIT_KEY) || (state_q == JUDGE);
  assign game_over      = (state_q == DONE);

endmodule

// File: tb/tb_challenge_issuer.sv
// Directed bench for challenge_issuer with a short timeout and a three-round game.
module tb_challenge_issuer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] random;
  logic       key_valid;
  logic [3:0] key_value;
  logic [3:0] code_out;
  logic       code_valid;
  logic [3:0] expected_key;
  logic       result_valid;
  logic       result_correct;
  logic       result_timeout;
  logic [3:0] score;
  logic       busy;
  logic       game_over;

  int checks_total;
  int checks_passed;
  int cnt;

  challenge_issuer #(.TIMEOUT_CYCLES(10), .ROUNDS(3), .SCORE_W(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .random         (random),
    .key_valid      (key_valid),
    .key_value      (key_value),
    .code_out       (code_out),
    .code_valid     (code_valid),
    .expected_key   (expected_key),
    .result_valid   (result_valid),
    .result_correct (result_correct),
    .result_timeout (result_timeout),
    .score          (score),
    .busy           (busy),
    .game_over      (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] outs_s;
  assign outs_s = {code_out, code_valid, expected_key, result_valid, result_correct,
                   result_timeout, score, busy, game_over};

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    random    = 8'h00;
    key_valid = 1'b0;
    key_value = 4'd0;
    #12;
    check("reset_outputs", 32'(outs_s), 32'd0);
    reset_n = 1'b1;
    tick();

    // game 1, round 1: code 3 -> key 9, correct press
    random = 8'hA3;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("issue_no_code_valid", 32'(code_valid), 32'd0);
    check("issue_busy", 32'(busy), 32'd1);
    tick();
    check("r1_code_valid", 32'(code_valid), 32'd1);
    check("r1_code_out", 32'(code_out), 32'd3);
    check("r1_expected", 32'(expected_key), 32'd9);
    key_valid = 1'b1;
    key_value = 4'd9;
    tick();
    key_valid = 1'b0;
    check("r1_result", 32'({result_valid, result_correct, result_timeout}), 32'b110);
    random = 8'h05;
    tick();
    check("r1_score", 32'(score), 32'd1);
    check("r1_pulse_gone", 32'(result_valid), 32'd0);

    // round 2: code 5 -> key 10, wrong press 4
    tick();
    check("r2_code_out", 32'(code_out), 32'd5);
    check("r2_expected", 32'(expected_key), 32'd10);
    key_valid = 1'b1;
    key_value = 4'd4;
    tick();
    key_valid = 1'b0;
    check("r2_result", 32'({result_valid, result_correct, result_timeout}), 32'b100);
    random = 8'h0C;
    tick();
    check("r2_score", 32'(score), 32'd1);

    // round 3: no press, timeout after exactly 10 cycles
    tick();
    check("r3_code_valid", 32'(code_valid), 32'd1);
    cnt = 0;
    while (!result_valid && cnt < 50) begin
      tick();
      cnt++;
    end
    check("r3_timeout_latency", 32'(cnt), 32'd10);
    check("r3_result", 32'({result_valid, result_correct, result_timeout}), 32'b101);
    tick();
    check("g1_done", 32'({game_over, busy, score}), 32'({1'b1, 1'b0, 4'd1}));
    check("g1_hold_code", 32'({code_out, expected_key}), 32'({4'd12, 4'd5}));

    // game 2: press on the very cycle the timer reaches zero
    random = 8'h01;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("g2_score_clear", 32'({score, game_over}), 32'd0);
    tick();
    for (int i = 0; i < 9; i++) tick();
    check("g2_still_waiting", 32'({code_valid, result_valid}), 32'b10);
    key_valid = 1'b1;
    key_value = 4'd1;
    tick();
    key_valid = 1'b0;
    check("g2_edge_press", 32'({result_valid, result_correct, result_timeout}), 32'b110);
    random = 8'h32;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("g2_start_ignored", 32'({busy, score}), 32'({1'b1, 4'd1}));
    tick();
    check("g2_r2_expected", 32'({code_out, expected_key}), 32'({4'd2, 4'd4}));
    key_valid = 1'b1;
    key_value = 4'd4;
    tick();
    key_valid = 1'b0;
    random = 8'hFF;
    tick();
    tick();
    check("g2_r3_expected", 32'({code_out, expected_key}), 32'({4'd15, 4'd12}));
    key_valid = 1'b1;
    key_value = 4'd12;
    tick();
    key_valid = 1'b0;
    check("g2_r3_result", 32'({result_valid, result_correct}), 32'b11);
    tick();
    check("g2_done", 32'({game_over, busy, score}), 32'({1'b1, 1'b0, 4'd3}));
    key_valid = 1'b1;
    key_value = 4'd0;
    tick();
    key_valid = 1'b0;
    check("done_key_ignored", 32'({game_over, result_valid, score}), 32'({1'b1, 1'b0, 4'd3}));

    // game 3: repeated code 7 twice
    random = 8'h07;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("g3_restart", 32'({busy, game_over, score}), 32'({1'b1, 1'b0, 4'd0}));
    tick();
    check("g3_r1_code", 32'({code_out, expected_key}), 32'({4'd7, 4'd6}));
    key_valid = 1'b1;
    key_value = 4'd6;
    tick();
    key_valid = 1'b0;
    tick();
    tick();
`ifdef CHALLENGE_NO_REPEAT_EN
    check("g3_r2_code", 32'({code_out, expected_key}), 32'({4'd8, 4'd15}));
`else
    check("g3_r2_code", 32'({code_out, expected_key}), 32'({4'd7, 4'd6}));
`endif
    tick();
    tick();
    check("g3_mid_wait", 32'(code_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midround_reset", 32'(outs_s), 32'd0);
    tick();
    check("held_in_reset", 32'(outs_s), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
